// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared constants and response type for the ROM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_FETCH = 0;
    localparam int PORT_LOAD  = 1;
    localparam int RESP_DATA_WIDTH = 32;

    typedef struct packed {
        logic [RESP_DATA_WIDTH-1:0] data;
        logic                       err;
    } resp_t;

endpackage : rom_arb_pkg
`default_nettype wire

// File: rtl/rom_arb_resp_slot.sv
`default_nettype none
// ============================================================================
// Module      : rom_arb_resp_slot
// Description : One-entry registered response buffer with valid/ready.
//               A load always wins over a consume so a consumed entry can be
//               replaced in the same cycle without a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arb_resp_slot
    import rom_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  consume,
    input  resp_t load_resp,
    output logic  valid,
    output resp_t resp
);

    logic  r_valid;
    resp_t r_resp;

    // Slot state: load new response, else drop it when consumed, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_resp  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_resp  <= load_resp;
        end else if (consume) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign resp  = r_resp;

endmodule : rom_arb_resp_slot
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Round-robin arbiter sharing one combinational ROM read port
//               between instruction fetch (port 0) and data load (port 1).
//               Bad addresses (misaligned / out of range) return an error
//               response with zero data.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH_BYTES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  req_valid,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_PORTS-1:0]                  req_ready,
    output logic [NUM_PORTS-1:0]                  resp_valid,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  resp_data,
    output logic [NUM_PORTS-1:0]                  resp_err,
    input  logic [NUM_PORTS-1:0]                  resp_ready,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]                 mem_data
);

    // Highest legal word-aligned byte address.
    localparam logic [ADDR_WIDTH-1:0] C_MAX_ADDR = ADDR_WIDTH'(MEM_DEPTH_BYTES - 4);

    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_err;
    resp_t                w_load_resp;
    logic                 r_last_grant;   // 1 = load port granted most recently
    logic [NUM_PORTS-1:0] w_slot_valid;
    resp_t                w_slot_resp [NUM_PORTS];

    // A port may be granted only if its slot is free or is being drained now.
    assign w_elig = req_valid & (~w_slot_valid | resp_ready);

    // Round-robin grant: a tie goes to the port not granted most recently.
    always_comb begin
        w_grant = w_elig;
        if (w_elig[PORT_FETCH] && w_elig[PORT_LOAD]) begin
            w_grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Steer the granted address onto the ROM; idle address is zero.
    always_comb begin
        mem_addr = '0;
        if (w_grant[PORT_FETCH]) begin
            mem_addr = req_addr[PORT_FETCH];
        end else if (w_grant[PORT_LOAD]) begin
            mem_addr = req_addr[PORT_LOAD];
        end
    end

    assign req_ready = w_grant;

    // Error detection on the address actually presented to the ROM.
    always_comb begin
        w_err            = (mem_addr[1:0] != 2'b00) || (mem_addr > C_MAX_ADDR);
        w_load_resp.err  = w_err;
        w_load_resp.data = w_err ? '0 : mem_data;
    end

    // Remember the winner; idle cycles leave the priority unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant[PORT_LOAD];
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
        rom_arb_resp_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_grant[p]),
            .consume   (resp_ready[p]),
            .load_resp (w_load_resp),
            .valid     (w_slot_valid[p]),
            .resp      (w_slot_resp[p])
        );
        assign resp_data[p] = w_slot_resp[p].data;
        assign resp_err[p]  = w_slot_resp[p].err;
    end : g_slot

    assign resp_valid = w_slot_valid;

endmodule : rom_port_arbiter
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_port_arbiter
// Description : Directed self-checking bench for rom_port_arbiter with a
//               simple ROM model whose word at byte address A is
//               0xC0DE0000 | A[15:0].
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_addr;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [1:0][31:0]  resp_data;
    logic [1:0]        resp_err;
    logic [1:0]        resp_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data;

    int n_checks;
    int n_errors;

    rom_port_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MEM_DEPTH_BYTES (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    // ROM model: combinational from mem_addr.
    assign mem_data = 32'hC0DE_0000 | {16'h0, mem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] fetch_addrs [3];
        logic [31:0] exp_data;
        int          exp_g;

        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_addr   = '0;
        resp_ready = 2'b00;

        // Reset state
        step();
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_resp_data",  resp_data,  64'h0);
        check("rst_resp_err",   resp_err,   2'b00);
        check("rst_req_ready",  req_ready,  2'b00);
        check("rst_mem_addr",   mem_addr,   32'h0);
        rst_n = 1'b1;
        step();

        // Fetch-only back-to-back stream
        fetch_addrs[0] = 32'h0;
        fetch_addrs[1] = 32'h4;
        fetch_addrs[2] = 32'h8;
        resp_ready = 2'b11;
        req_valid  = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_addr[0] = fetch_addrs[i];
            #1;
            check("fetch_req_ready", req_ready, 2'b01);
            check("fetch_mem_addr",  mem_addr,  fetch_addrs[i]);
            step();
            exp_data = 32'hC0DE_0000 | fetch_addrs[i];
            check("fetch_resp_valid", resp_valid[0], 1'b1);
            check("fetch_resp_data",  resp_data[0],  exp_data);
            check("fetch_resp_err",   resp_err[0],   1'b0);
        end
        req_valid = 2'b00;
        step();
        check("fetch_drained", resp_valid, 2'b00);

        // Both ports every cycle: port 0 was last, so port 1 wins the first tie
        req_valid   = 2'b11;
        req_addr[0] = 32'h10;
        req_addr[1] = 32'h20;
        exp_g       = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_req_ready", req_ready, (exp_g == 1) ? 2'b10 : 2'b01);
            check("rr_mem_addr",  mem_addr,  (exp_g == 1) ? 32'h20 : 32'h10);
            step();
            check("rr_resp_valid", resp_valid, (exp_g == 1) ? 2'b10 : 2'b01);
            check("rr_resp_data",  resp_data[exp_g],
                  (exp_g == 1) ? 32'hC0DE_0020 : 32'hC0DE_0010);
            exp_g = 1 - exp_g;
        end

        // Address error checks on the load port
        req_valid   = 2'b10;
        req_addr[1] = 32'h3FE;
        step();
        check("err_misalign_err",  resp_err[1],  1'b1);
        check("err_misalign_data", resp_data[1], 32'h0);
        req_addr[1] = 32'h400;
        step();
        check("err_range_err",  resp_err[1],  1'b1);
        check("err_range_data", resp_data[1], 32'h0);
        req_addr[1] = 32'h3FC;
        step();
        check("ok_last_err",   resp_err[1],   1'b0);
        check("ok_last_valid", resp_valid[1], 1'b1);
        check("ok_last_data",  resp_data[1],  32'hC0DE_03FC);

        // Back-pressure on fetch: fill its slot, then stall the consumer
        req_valid   = 2'b01;
        req_addr[0] = 32'h8;
        resp_ready  = 2'b10;
        step();
        check("bp_fill_data", resp_data[0], 32'hC0DE_0008);
        req_valid   = 2'b11;
        req_addr[0] = 32'h10;
        req_addr[1] = 32'h20;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_req_ready", req_ready, 2'b10);
            check("bp_mem_addr",  mem_addr,  32'h20);
            step();
            check("bp_resp_valid", resp_valid, 2'b11);
            check("bp_hold_data",  resp_data[0], 32'hC0DE_0008);
        end

        // Asynchronous reset mid-cycle with both slots full
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 2'b00);
        check("arst_resp_data",  resp_data,  64'h0);
        check("arst_resp_err",   resp_err,   2'b00);
        check("arst_req_ready",  req_ready,  2'b00);
        check("arst_mem_addr",   mem_addr,   32'h0);
        step();
        rst_n = 1'b1;
        #1;

        // First tie after reset goes to port 0, then port 1
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        #1;
        check("post_rst_tie_ready", req_ready, 2'b01);
        check("post_rst_tie_addr",  mem_addr,  32'h10);
        step();
        check("post_rst_resp0", resp_data[0], 32'hC0DE_0010);
        check("post_rst_second", req_ready, 2'b10);
        req_valid = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_rom_port_arbiter
`default_nettype wire
